mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have parameter USE_MEM_READY, default 1, meaning: 1 = memory states wait on mem_ready; 0 = mem_ready ignored and treated as 1.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; reset is asynchronous and active-low.
REQ-004 The block SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 The block SHALL have port zero, input, 1, ALU zero flag.
REQ-006 The block SHALL have port mem_ready, input, 1, memory access complete this cycle.
REQ-007 The block SHALL have port IorD, output, 1, address-select to the memory-address mux: 0 = PC, 1 = ALUOut register.
REQ-008 The block SHALL have outputs MemWrite, IRWrite, RegDst, MemtoReg, RegWrite and ALUSrcA, each output, 1, standard multicycle datapath strobes/selects.
REQ-009 The block SHALL have outputs ALUSrcB, ALUOp and PCSrc, each output, 2, standard multicycle selects.
REQ-010 The block SHALL have output pc_en, 1, PC register load enable.
REQ-011 The block SHALL have output illegal_op, 1, one-cycle pulse on an unrecognised opcode.
REQ-012 The block SHALL have output state, 4, current state encoding for debug.

Function
REQ-013 States SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 are unused and SHALL go to FETCH on the next edge.
REQ-014 Transitions SHALL be:
- FETCH: to DECODE when ready, else stay.
- DECODE: by opcode -- LW(100011)/SW(101011)->MEMADR, R-type(000000)->EXEC, BEQ(000100)->BRANCH, ADDI(001000)->ADDIEX, J(000010)->JUMP, else->FETCH with illegal_op=1 for that cycle.
- MEMADR: LW->MEMRD, SW->MEMWR.
- MEMRD: to MEMWB when ready, else stay.
- MEMWR: to FETCH when ready, else stay.
- MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: to FETCH.
- EXEC->ALUWB; ADDIEX->ADDIWB.
REQ-015 ready SHALL equal (mem_ready | ~USE_MEM_READY).
REQ-016 Outputs SHALL be combinational from state (plus ready/zero where stated); every output not listed for a state SHALL be 0.
- FETCH: IorD=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=ready, pc_en=ready.
- DECODE: ALUSrcB=11, ALUOp=00.
- MEMADR/ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMRD: IorD=1.
- MEMWR: IorD=1, MemWrite=ready.
- MEMWB: MemtoReg=1, RegWrite=1.
- EXEC: ALUSrcA=1, ALUOp=10.
- ALUWB: RegDst=1, RegWrite=1.
- ADDIWB: RegWrite=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, pc_en=zero.
- JUMP: PCSrc=10, pc_en=1.
REQ-017 Instruction latency with ready held at 1 SHALL be: LW 5 cycles, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
REQ-018 MemWrite SHALL assert only in the single cycle in which MEMWR completes; IRWrite and pc_en in FETCH SHALL assert only in the single cycle in which ready=1.
REQ-019 opcode SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.

Reset
REQ-020 rst_n=0 SHALL force state to FETCH immediately, independent of clk, including mid-instruction (e.g. in MEMWR with ready=0).
REQ-021 During reset, outputs SHALL equal the FETCH decode: IorD=0, ALUSrcB=01, MemWrite=0, RegWrite=0, illegal_op=0, and IRWrite=pc_en=ready.
REQ-022 Deassertion of rst_n SHALL take effect at the first rising clk edge after it.

Structure
REQ-023 State codes, opcode constants, and ALUOp/PCSrc/ALUSrcB encodings SHALL live in a shared package (mc_defs) used by this block and the datapath.
REQ-024 The block SHALL be two processes: state register and next-state/output decode; no sub-module is required.

Verification
REQ-025 LW with ready=1: reset, then opcode=100011 -> states 0,1,2,3,4,0; IorD=1 in MEMRD; RegWrite=1 and MemtoReg=1 in MEMWB.
REQ-026 SW with mem_ready low for 3 cycles in MEMWR -> state holds 5 with MemWrite=0, then MemWrite=1 for exactly one cycle, then FETCH.
REQ-027 BEQ with zero=1 -> pc_en=1 and PCSrc=01 in BRANCH; repeat with zero=0 -> pc_en=0.
REQ-028 opcode=111111 -> illegal_op=1 for one cycle in DECODE, then FETCH.
REQ-029 rst_n pulled low mid-MEMRD with clk stopped -> state=0 and IorD=0 immediately.
REQ-030 USE_MEM_READY=0 with mem_ready tied to 0 -> R-type completes in 4 cycles.

Source files
------------

// File: rtl/mc_defs.sv
`timescale 1ns/1ps
// Shared encodings for the multicycle controller and its datapath:
// state codes, opcodes and the ALU / PC / operand-select encodings.
package mc_defs;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mc_control_fsm.sv
`timescale 1ns/1ps
// Multicycle MIPS-style controller: state register plus a single
// combinational process producing next state and all datapath controls.
module mc_control_fsm
    import mc_defs::*;
#(
    parameter logic USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   ready;

    assign ready = mem_ready | ~USE_MEM_READY;
    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUOp      = ALUOP_ADD;
        PCSrc      = PCSRC_ALU;
        pc_en      = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB = SRCB_FOUR;
                IRWrite = ready;
                pc_en   = ready;
                state_d = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = ready;
                state_d  = ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                pc_en   = zero;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc = PCSRC_JUMP;
                pc_en = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
`timescale 1ns/1ps
// Scoreboard bench for mc_control_fsm: stimulus pushes expected per-cycle
// control words, a negedge monitor pops and compares them.
module tb_mc_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, aluop, pcsrc;
        logic       pc_en, illegal;
    } obs_t;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
        ST_MEMRD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWR = 4'd5, ST_EXEC = 4'd6,
        ST_ALUWB = 4'd7, ST_BRANCH = 4'd8, ST_ADDIEX = 4'd9, ST_ADDIWB = 4'd10,
        ST_JUMP = 4'd11;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

    logic clk = 1'b0;
    logic clk_run = 1'b1;
    logic rst_n, zero, mem_ready;
    logic [5:0] opcode;
    logic IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, pc_en, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state;

    logic rst0_n;
    logic [5:0] op0 = 6'b000000;
    logic IorD0, MemWrite0, IRWrite0, RegDst0, MemtoReg0, RegWrite0, ALUSrcA0, pc_en0, illegal0;
    logic [1:0] ALUSrcB0, ALUOp0, PCSrc0;
    logic [3:0] state0;

    int n_checks = 0;
    int n_fail = 0;
    obs_t sb_q[$];
    obs_t obs;

    assign obs = {state, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSrc, pc_en, illegal_op};

    mc_control_fsm #(.USE_MEM_READY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .pc_en(pc_en), .illegal_op(illegal_op), .state(state)
    );

    mc_control_fsm #(.USE_MEM_READY(1'b0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .opcode(op0), .zero(1'b0), .mem_ready(1'b0),
        .IorD(IorD0), .MemWrite(MemWrite0), .IRWrite(IRWrite0), .RegDst(RegDst0),
        .MemtoReg(MemtoReg0), .RegWrite(RegWrite0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0),
        .ALUOp(ALUOp0), .PCSrc(PCSrc0), .pc_en(pc_en0), .illegal_op(illegal0), .state(state0)
    );

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: expected control word for a cycle, straight from the state table.
    function automatic obs_t exp_out(input logic [3:0] st, input logic rdy, input logic z,
                                     input logic ill);
        obs_t o = '0;
        o.st = st;
        case (st)
            ST_FETCH:  begin o.alusrcb = 2'b01; o.irwrite = rdy; o.pc_en = rdy; end
            ST_DECODE: begin o.alusrcb = 2'b11; o.illegal = ill; end
            ST_MEMADR, ST_ADDIEX: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            ST_MEMRD:  o.iord = 1'b1;
            ST_MEMWB:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
            ST_MEMWR:  begin o.iord = 1'b1; o.memwrite = rdy; end
            ST_EXEC:   begin o.alusrca = 1'b1; o.aluop = 2'b10; end
            ST_ALUWB:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
            ST_BRANCH: begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pc_en = z; end
            ST_ADDIWB: o.regwrite = 1'b1;
            ST_JUMP:   begin o.pcsrc = 2'b10; o.pc_en = 1'b1; end
            default:   o = '0;
        endcase
        return o;
    endfunction

    function automatic int kind(input logic [5:0] op);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b000100: return K_BEQ;
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
            default:   return K_ILL;
        endcase
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) check("cycle", 32'(obs), 32'(sb_q.pop_front()));
    end

    // One clock of stimulus: drive inputs, record the expected word, advance.
    task automatic step(input logic [3:0] st, input logic rdy, input logic [5:0] opv,
                        input logic z, input logic ill);
        mem_ready = rdy;
        opcode    = opv;
        zero      = z;
        sb_q.push_back(exp_out(st, rdy, z, ill));
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic z, input int unsigned fw,
                             input int unsigned mw);
        int k = kind(op);
        for (int unsigned i = 0; i < fw; i++) step(ST_FETCH, 1'b0, rop(), rb(), 1'b0);
        step(ST_FETCH, 1'b1, rop(), rb(), 1'b0);
        step(ST_DECODE, rb(), op, rb(), k == K_ILL);
        case (k)
            K_LW: begin
                step(ST_MEMADR, rb(), op, rb(), 1'b0);
                for (int unsigned i = 0; i < mw; i++) step(ST_MEMRD, 1'b0, rop(), rb(), 1'b0);
                step(ST_MEMRD, 1'b1, rop(), rb(), 1'b0);
                step(ST_MEMWB, rb(), rop(), rb(), 1'b0);
            end
            K_SW: begin
                step(ST_MEMADR, rb(), op, rb(), 1'b0);
                for (int unsigned i = 0; i < mw; i++) step(ST_MEMWR, 1'b0, rop(), rb(), 1'b0);
                step(ST_MEMWR, 1'b1, rop(), rb(), 1'b0);
            end
            K_R: begin
                step(ST_EXEC, rb(), rop(), rb(), 1'b0);
                step(ST_ALUWB, rb(), rop(), rb(), 1'b0);
            end
            K_ADDI: begin
                step(ST_ADDIEX, rb(), rop(), rb(), 1'b0);
                step(ST_ADDIWB, rb(), rop(), rb(), 1'b0);
            end
            K_BEQ:   step(ST_BRANCH, rb(), rop(), z, 1'b0);
            K_J:     step(ST_JUMP, rb(), rop(), rb(), 1'b0);
            default: ;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] ops[6];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        rst_n = 1'b0; rst0_n = 1'b1; mem_ready = 1'b1; opcode = '0; zero = 1'b0;
        #12;
        check("reset_ready1", 32'(obs), 32'(exp_out(ST_FETCH, 1'b1, 1'b0, 1'b0)));
        mem_ready = 1'b0;
        #1;
        check("reset_ready0", 32'(obs), 32'(exp_out(ST_FETCH, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_instr(6'b100011, 1'b0, 0, 0);   // LW 0,1,2,3,4
        run_instr(6'b101011, 1'b0, 0, 3);   // SW with three MEMWR stalls
        run_instr(6'b000100, 1'b1, 0, 0);
        run_instr(6'b000100, 1'b0, 1, 0);
        run_instr(6'b111111, 1'b0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            int unsigned sel = $urandom_range(0, 7);
            logic [5:0] op = (sel < 6) ? ops[sel] : rop();
            run_instr(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Asynchronous reset mid-MEMRD with the clock stopped.
        step(ST_FETCH, 1'b1, rop(), 1'b0, 1'b0);
        step(ST_DECODE, 1'b1, 6'b100011, 1'b0, 1'b0);
        step(ST_MEMADR, 1'b1, 6'b100011, 1'b0, 1'b0);
        mem_ready = 1'b0;
        sb_q.push_back(exp_out(ST_MEMRD, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        clk_run = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'(ST_FETCH));
        check("async_rst_iord", 32'(IorD), 32'd0);
        #3;
        rst_n = 1'b1;
        #2;
        clk_run = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_hold", 32'(state), 32'(ST_FETCH));
        run_instr(6'b000000, 1'b0, 0, 0);

        // Instance with USE_MEM_READY=0 and mem_ready tied low: R-type in 4 cycles.
        @(negedge clk);
        rst0_n = 1'b0;
        #1;
        rst0_n = 1'b1;
        check("nomr_fetch", 32'(state0), 32'(ST_FETCH));
        check("nomr_irwrite", 32'({IRWrite0, pc_en0}), 32'd3);
        @(posedge clk); #1; check("nomr_c1", 32'(state0), 32'(ST_DECODE));
        @(posedge clk); #1; check("nomr_c2", 32'(state0), 32'(ST_EXEC));
        @(posedge clk); #1; check("nomr_c3", 32'(state0), 32'(ST_ALUWB));
        @(posedge clk); #1; check("nomr_c4", 32'(state0), 32'(ST_FETCH));

        @(posedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
